// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] WORD_BYTES        = 32'd4;
   localparam logic [31:0] DEFAULT_NOP_WORD  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam int unsigned DEFAULT_MEM_WORDS = 32;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: fetch drives the address, memory answers
// combinationally with the word at that address.
interface instruction_fetch_if;
   logic [31:0] imem_address;
   logic [31:0] imem_data;

   modport master (output imem_address, input imem_data);
   modport slave  (input imem_address, output imem_data);
endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage (purely combinational).
// Chooses between hold, PC+4 and the word-aligned redirect target.
module fetch_next_pc
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_LIMIT = 32'd128
) (
   input  logic [31:0]  pc,
   input  fetch_state_t state,
   input  logic         stall,
   input  logic         redirect,
   input  logic [31:0]  target,
   output logic [31:0]  next_pc,
   output logic [31:0]  pc_inc
);

   assign pc_inc = pc + WORD_BYTES;

   // Priority: redirect, then out-of-range hold, then stall hold, then advance.
   always_comb begin
      next_pc = pc;
      case (state)
         RUN: begin
            if (redirect)
               next_pc = align_word(target);
            else if (pc >= PC_LIMIT)
               next_pc = pc;
            else if (!stall)
               next_pc = pc_inc;
         end
         HALT: begin
            // Only an in-range redirect can restart fetch.
            if (redirect && (target < PC_LIMIT))
               next_pc = align_word(target);
         end
         default: next_pc = pc;
      endcase
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and
// registers the returned word into IF/ID. Handles stall, branch flush and
// halting at the end of program memory.
// Optional: define FETCH_ALIGN_CHECK_EN to flag misaligned branch targets
// (sticky misalign_err) and suppress such redirects instead of masking them.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
   parameter logic [31:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       branch_taken,
   input  logic [31:0]                branch_target,
   instruction_fetch_if.master        imem,
   output logic [31:0]                instr,
   output logic [31:0]                pc_plus4,
   output logic                       instr_valid,
   output logic                       halted
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic                       misalign_err
`endif
);

   localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS) * WORD_BYTES;

   logic [31:0]  pc;
   logic [31:0]  next_pc;
   logic [31:0]  pc_inc;
   fetch_state_t state;
   logic         redirect;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
   // A misaligned target is dropped entirely: fetch carries on down the
   // sequential path with no flush.
   assign redirect   = branch_taken && !misaligned;
`else
   assign redirect   = branch_taken;
`endif

   assign imem.imem_address = pc;
   assign halted            = (state == HALT);

   fetch_next_pc #(
      .PC_LIMIT (PC_LIMIT)
   ) u_next_pc (
      .pc       (pc),
      .state    (state),
      .stall    (stall),
      .redirect (redirect),
      .target   (branch_target),
      .next_pc  (next_pc),
      .pc_inc   (pc_inc)
   );

   // PC, IF/ID register and RUN/HALT state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr       <= NOP_WORD;
         pc_plus4    <= 32'd0;
         instr_valid <= 1'b0;
         state       <= RUN;
      end else begin
         pc <= next_pc;
         case (state)
            RUN: begin
               if (redirect) begin
                  // Flush the wrong-path word; pc_plus4 keeps its last value.
                  instr       <= NOP_WORD;
                  instr_valid <= 1'b0;
               end else if (pc >= PC_LIMIT) begin
                  // Landed past the end (e.g. via a branch): stop without capturing.
                  instr       <= NOP_WORD;
                  instr_valid <= 1'b0;
                  state       <= HALT;
               end else if (!stall) begin
                  instr       <= imem.imem_data;
                  pc_plus4    <= pc_inc;
                  instr_valid <= 1'b1;
                  // Last word is still captured; fetch stops right after.
                  if (pc_inc == PC_LIMIT)
                     state <= HALT;
               end
            end
            HALT: begin
               instr       <= NOP_WORD;
               instr_valid <= 1'b0;
               if (redirect && (branch_target < PC_LIMIT))
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Sticky misaligned-target flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         misalign_err <= 1'b0;
      else if (misaligned)
         misalign_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table,
// hand-written reset/alignment sequences, then random stimulus checked
// against a behavioural model of the fetch rules.
module tb_instruction_fetch;

   localparam int unsigned    MEM_WORDS = 32;
   localparam logic [31:0]    LIMIT     = 32'(MEM_WORDS * 4);
   localparam logic [31:0]    NOP       = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic [31:0] instr, pc_plus4;
   logic        instr_valid, halted;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   logic [31:0] mem [MEM_WORDS];

   int nerr = 0;
   int nchk = 0;

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_PC  (32'h0),
      .MEM_WORDS (MEM_WORDS),
      .NOP_WORD  (NOP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (bus),
      .instr         (instr),
      .pc_plus4      (pc_plus4),
      .instr_valid   (instr_valid),
      .halted        (halted)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_err  (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   // Combinational instruction memory; out-of-range reads return junk.
   always_comb begin
      if (bus.imem_address < LIMIT)
         bus.imem_data = mem[bus.imem_address[6:2]];
      else
         bus.imem_data = 32'hBAD0_0000 ^ bus.imem_address;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
      reset = rst; stall = st; branch_taken = br; branch_target = tgt;
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_pc, m_instr, m_pp4;
   logic        m_valid, m_halted, m_err;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < LIMIT) return mem[a[6:2]];
      return 32'hBAD0_0000 ^ a;
   endfunction

   task automatic model_step(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
      logic take;
      if (rst) begin
         m_pc = 0; m_instr = NOP; m_pp4 = 0; m_valid = 0; m_halted = 0; m_err = 0;
         return;
      end
      take = br;
`ifdef FETCH_ALIGN_CHECK_EN
      if (br && tgt[1:0] != 2'b00) begin
         m_err = 1;
         take  = 0;
      end
`endif
      if (m_halted) begin
         m_instr = NOP; m_valid = 0;
         if (take && tgt < LIMIT) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_halted = 0;
         end
      end else if (take) begin
         m_pc = tgt & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 0;
      end else if (m_pc >= LIMIT) begin
         m_halted = 1; m_instr = NOP; m_valid = 0;
      end else if (!st) begin
         m_instr = mem_word(m_pc);
         m_pp4   = m_pc + 4;
         m_valid = 1;
         m_pc    = m_pc + 4;
         if (m_pc == LIMIT) m_halted = 1;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        st, br;
      logic [31:0] tgt, pc, ins, pp4;
      logic        vld, hlt;
   } vec_t;

   vec_t tv[18];

   function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] pp4, input logic vld, input logic hlt);
      vec_t v;
      v.st = st; v.br = br; v.tgt = tgt; v.pc = pc; v.ins = ins;
      v.pp4 = pp4; v.vld = vld; v.hlt = hlt;
      return v;
   endfunction

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] pp4, input logic vld, input logic hlt);
      chk({tag, " pc"},     bus.imem_address, pc);
      chk({tag, " instr"},  instr, ins);
      chk({tag, " pc4"},    pc_plus4, pp4);
      chk({tag, " valid"},  32'(instr_valid), 32'(vld));
      chk({tag, " halted"}, 32'(halted), 32'(hlt));
   endtask

   initial begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h1000 + 32'(i);

      tv[0]  = mk(0, 0, 32'h00,  32'h04,  32'h1000, 32'h04, 1, 0);
      tv[1]  = mk(0, 0, 32'h00,  32'h08,  32'h1001, 32'h08, 1, 0);
      tv[2]  = mk(1, 0, 32'h00,  32'h08,  32'h1001, 32'h08, 1, 0);
      tv[3]  = mk(1, 0, 32'h00,  32'h08,  32'h1001, 32'h08, 1, 0);
      tv[4]  = mk(0, 0, 32'h00,  32'h0C,  32'h1002, 32'h0C, 1, 0);
      tv[5]  = mk(0, 1, 32'h14,  32'h14,  NOP,      32'h0C, 0, 0);
      tv[6]  = mk(0, 0, 32'h00,  32'h18,  32'h1005, 32'h18, 1, 0);
      tv[7]  = mk(1, 1, 32'h20,  32'h20,  NOP,      32'h18, 0, 0);
      tv[8]  = mk(0, 0, 32'h00,  32'h24,  32'h1008, 32'h24, 1, 0);
      tv[9]  = mk(0, 1, 32'h7C,  32'h7C,  NOP,      32'h24, 0, 0);
      tv[10] = mk(0, 0, 32'h00,  32'h80,  32'h101F, 32'h80, 1, 1);
      tv[11] = mk(0, 0, 32'h00,  32'h80,  NOP,      32'h80, 0, 1);
      tv[12] = mk(0, 1, 32'h84,  32'h80,  NOP,      32'h80, 0, 1);
      tv[13] = mk(1, 0, 32'h00,  32'h80,  NOP,      32'h80, 0, 1);
      tv[14] = mk(0, 1, 32'h00,  32'h00,  NOP,      32'h80, 0, 0);
      tv[15] = mk(0, 0, 32'h00,  32'h04,  32'h1000, 32'h04, 1, 0);
      tv[16] = mk(0, 1, 32'h100, 32'h100, NOP,      32'h04, 0, 0);
      tv[17] = mk(0, 0, 32'h00,  32'h100, NOP,      32'h04, 0, 1);

      // Reset state.
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk_all("reset", 32'h0, NOP, 32'h0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("reset err", 32'(misalign_err), 32'h0);
`endif

      foreach (tv[i]) begin
         step(0, tv[i].st, tv[i].br, tv[i].tgt);
         chk_all($sformatf("v%0d", i), tv[i].pc, tv[i].ins, tv[i].pp4, tv[i].vld, tv[i].hlt);
      end

      // Reset while halted, with a branch also requested.
      step(1, 1, 1, 32'h40);
      chk_all("rst_halt", 32'h0, NOP, 32'h0, 0, 0);

      // Reset in the same cycle as a redirect.
      step(0, 0, 0, 0);
      step(1, 0, 1, 32'h40);
      chk_all("rst_br", 32'h0, NOP, 32'h0, 0, 0);

      // Misaligned branch target at PC=0x08.
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'h16);
`ifdef FETCH_ALIGN_CHECK_EN
      chk_all("misal", 32'h0C, 32'h1002, 32'h0C, 1, 0);
      chk("misal err", 32'(misalign_err), 32'h1);
      step(0, 0, 0, 0);
      chk("misal sticky", 32'(misalign_err), 32'h1);
`else
      chk_all("misal", 32'h14, NOP, 32'h08, 0, 0);
`endif

      // ---------------- randomized phase ----------------
      for (int i = 0; i < int'(MEM_WORDS); i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      model_step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         logic        r_rst, r_st, r_br;
         logic [31:0] r_tgt;
         r_rst = ($urandom_range(0, 49) == 0);
         r_st  = ($urandom_range(0, 9) < 3);
         r_br  = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 3) == 0)
            r_tgt = LIMIT + 32'($urandom_range(0, 7) * 4);
         else
            r_tgt = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
         if ($urandom_range(0, 7) == 0) r_tgt = r_tgt | 32'($urandom_range(1, 3));
         model_step(r_rst, r_st, r_br, r_tgt);
         step(r_rst, r_st, r_br, r_tgt);
         chk_all($sformatf("r%0d", n), m_pc, m_instr, m_pp4, m_valid, m_halted);
`ifdef FETCH_ALIGN_CHECK_EN
         chk($sformatf("r%0d err", n), 32'(misalign_err), 32'(m_err));
`endif
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
